// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard
// ----------------------------------------------------------------------------
// Scoreboard hazard unit that sits beside the ID stage. It is the successor to
// the fixed load-use/branch detector.
//
// The unit tracks pending register writes from variable-latency operations
// (ALU, load, mul/div). It decides when the pipeline must stall IF/ID, insert
// a bubble into ID/EX, or flush on a taken branch. Operand forwarding itself
// stays in ForwardingUnit. This block only detects the cases that forwarding
// cannot cover yet.
//
// Every architectural register r has two pieces of state:
//   busy[r] : a write to r has issued and has not been retired by writeback
//   cnt[r]  : cycles left until the result can be forwarded (0 = forwardable)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   id_valid          ID holds a valid instruction
//   rs1_id, rs2_id    ID source registers
//   rs1_used/rs2_used ID instruction reads rs1 / rs2
//   rd_id, we_id      ID destination register and its write enable
//   lat_id            cycles after issue until rd is forwardable
//   wb_valid, wb_rd   writeback retires wb_rd this cycle
//   branch_taken_ex   EX-stage branch/jump redirects the PC
//   mem_wait          data memory not ready; the whole pipeline freezes
//   stall_if          hold PC
//   stall_id          hold IF/ID register
//   flush_id          clear IF/ID register
//   flush_ex          insert bubble into ID/EX
//   stall_cycles      performance counter: cycles lost to RAW/WAW stalls
//   flush_count       performance counter: branch flushes taken
//
// Build option
//   HAZARD_PERF_CNT_EN : when defined, stall_cycles and flush_count are
//                        saturating counters. When it is undefined, both
//                        ports are tied to zero and no counter flops exist.
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 7,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              we_id,
    input  logic [2:0]        lat_id,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              branch_taken_ex,
    input  logic              mem_wait,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // The state arrays cover the whole address space, so any rs/rd value can
    // be used as an index directly. Entries at or above NUM_REGS, and entry
    // 0, are held at zero. As a result, they never report a hazard.
    localparam int NREG_ALL = 1 << REG_AW;
    localparam int CW       = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [NREG_ALL-1:0] busy_q;
    logic [NREG_ALL-1:0] busy_d;
    logic [CW-1:0]       cnt_q [NREG_ALL];
    logic [CW-1:0]       cnt_d [NREG_ALL];

    logic [CW-1:0] lat_c;
    logic          src1_pending;
    logic          src2_pending;
    logic          raw;
    logic          waw;
    logic          hz;
    logic          issue;
    logic          retire;

    // A latency request above MAX_LAT is clamped, because the counters are
    // only wide enough for MAX_LAT.
    always_comb begin
        lat_c = CW'(lat_id);
        if (32'(lat_id) > 32'(MAX_LAT)) begin
            lat_c = CW'(MAX_LAT);
        end
    end

    // RAW: a source operand is still in flight and cannot be forwarded yet.
    // WAW: the ID instruction would become forwardable before an older write
    // to the same register. If the ID instruction issued, the older write
    // would land last and overwrite it, so it must wait.
    always_comb begin
        src1_pending = rs1_used & (rs1_id != '0) & busy_q[rs1_id] & (cnt_q[rs1_id] != '0);
        src2_pending = rs2_used & (rs2_id != '0) & busy_q[rs2_id] & (cnt_q[rs2_id] != '0);
        raw          = id_valid & (src1_pending | src2_pending);
        waw          = id_valid & we_id & (rd_id != '0) & busy_q[rd_id] & (cnt_q[rd_id] > lat_c);
        hz           = raw | waw;
        issue        = ~mem_wait & ~branch_taken_ex & ~hz & id_valid & we_id & (rd_id != '0);
        retire       = wb_valid & (wb_rd != '0);
    end

    // Pipeline control. A memory wait freezes everything and outranks the
    // other cases. Next in priority, a taken branch squashes both the IF/ID
    // and ID/EX contents. Last, a scoreboard hazard holds the front end and
    // sends a bubble down the pipe.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (mem_wait) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (branch_taken_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (hz) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    // Next scoreboard state for each register. Countdown stops while memory
    // is stalled, because the producing instruction is frozen as well. A
    // retirement still clears busy during a memory stall. When a new issue
    // and a retirement target the same register in the same cycle, the new
    // issue is applied last so that it wins. Busy stays set after cnt reaches
    // zero. In that state the value is forwardable, and the register stays
    // busy until writeback clears it.
    always_comb begin
        for (int r = 0; r < NREG_ALL; r++) begin
            busy_d[r] = busy_q[r];
            cnt_d[r]  = cnt_q[r];
            if (!mem_wait && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
            if (retire && (wb_rd == REG_AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (issue && (rd_id == REG_AW'(r))) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = lat_c;
            end
            if ((r == 0) || (r >= NUM_REGS)) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int r = 0; r < NREG_ALL; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREG_ALL; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             count_stall;
    logic             count_flush;

    // A cycle is counted only when it is actually lost to the event being
    // counted. A hazard cycle that is hidden by a memory wait or by a branch
    // flush is not counted as a stall cycle.
    always_comb begin
        count_stall = hz & ~mem_wait & ~branch_taken_ex;
        count_flush = branch_taken_ex & ~mem_wait;
    end

    // Saturating performance counters. Once a counter reaches all-ones it
    // stays there, so it never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (count_stall && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (count_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard
// ----------------------------------------------------------------------------
// Self-checking bench for hazard_scoreboard.
//
// The reference model does not keep a per-register down-counter. For every
// register it keeps a pending flag and the "active cycle" at which the value
// becomes forwardable. An active cycle is any cycle without mem_wait. The
// cycles still remaining are then ready_at minus the current active-cycle
// number, floored at zero.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 2 time units later, well away from the clock edge.
// ============================================================================
module tb_hazard_scoreboard;

    localparam int MAX_LAT = 7;
    localparam int CNT_W   = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd_id;
    logic       we_id;
    logic [2:0] lat_id;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       branch_taken_ex;
    logic       mem_wait;
    logic       stall_if;
    logic       stall_id;
    logic       flush_id;
    logic       flush_ex;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_AW(5), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_id(rd_id), .we_id(we_id), .lat_id(lat_id),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .branch_taken_ex(branch_taken_ex), .mem_wait(mem_wait),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit     m_pend  [32];
    longint m_ready [32];
    longint m_active;
    longint m_stall;
    longint m_flush;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    // Expectations for the cycle currently being driven.
    logic [3:0] exp_ctrl;
    bit         exp_hz;
    bit         exp_issue;

    function automatic longint remaining(input int r);
        return (m_ready[r] > m_active) ? (m_ready[r] - m_active) : 64'd0;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            m_pend[r]  = 1'b0;
            m_ready[r] = 0;
        end
        m_active = 0;
        m_stall  = 0;
        m_flush  = 0;
    endfunction

    // Expected control outputs, built from the hazard rules and their
    // priority order.
    function automatic void compute_expect();
        int  lat_c;
        bit  r1;
        bit  r2;
        bit  waw;
        lat_c = (int'(lat_id) > MAX_LAT) ? MAX_LAT : int'(lat_id);
        r1  = rs1_used && rs1_id != 0 && m_pend[rs1_id] && remaining(int'(rs1_id)) > 0;
        r2  = rs2_used && rs2_id != 0 && m_pend[rs2_id] && remaining(int'(rs2_id)) > 0;
        waw = we_id && rd_id != 0 && m_pend[rd_id] && remaining(int'(rd_id)) > lat_c;
        exp_hz = id_valid && (r1 || r2 || waw);
        if (mem_wait)             exp_ctrl = 4'b1100;
        else if (branch_taken_ex) exp_ctrl = 4'b0011;
        else if (exp_hz)          exp_ctrl = 4'b1101;
        else                      exp_ctrl = 4'b0000;
        exp_issue = !mem_wait && !branch_taken_ex && !exp_hz && id_valid && we_id && rd_id != 0;
    endfunction

    // Advance one clock edge and update the model from the inputs that were
    // applied before the edge.
    task automatic tick();
        int lat_c;
        compute_expect();
        lat_c = (int'(lat_id) > MAX_LAT) ? MAX_LAT : int'(lat_id);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (!mem_wait && !branch_taken_ex && exp_hz && m_stall < CNT_MAX) m_stall++;
            if (branch_taken_ex && !mem_wait && m_flush < CNT_MAX) m_flush++;
            if (!mem_wait) m_active++;
            if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 1'b0;
            if (exp_issue) begin
                m_pend[rd_id]  = 1'b1;
                m_ready[rd_id] = m_active + lat_c;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
        rd_id = 0; we_id = 0; lat_id = 0; wb_valid = 0; wb_rd = 0;
        branch_taken_ex = 0; mem_wait = 0;
    endtask

    task automatic set_write(input logic [4:0] rd, input logic [2:0] lat);
        set_idle();
        id_valid = 1; rd_id = rd; we_id = 1; lat_id = lat;
    endtask

    task automatic set_read(input logic [4:0] rs);
        set_idle();
        id_valid = 1; rs1_id = rs; rs1_used = 1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        tick();
        tick();
        set_read(5'd5);
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b expected 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        checks++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_load_use();
        int seen_stalls;
        seen_stalls = 0;
        set_write(5'd5, 3'd1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) set_read(5'd5);
            compute_expect(); #2;
            checks++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== exp_ctrl) begin
                errors++;
                $display("[TB] FAIL load_use_ctrl cycle %0d got %b expected %b", c, {stall_if, stall_id, flush_id, flush_ex}, exp_ctrl);
            end
            if (stall_id) seen_stalls++;
            tick();
        end
        checks++;
        if (seen_stalls !== 1) begin
            errors++;
            $display("[TB] FAIL load_use_len got %0d stall cycles expected 1", seen_stalls);
        end
        set_idle();
    endtask

    task automatic test_div_memwait();
        int k;
        set_write(5'd7, 3'd5);
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== exp_ctrl) begin
            errors++;
            $display("[TB] FAIL div_issue_ctrl got %b expected %b", {stall_if, stall_id, flush_id, flush_ex}, exp_ctrl);
        end
        tick();
        k = 0;
        do begin
            set_read(5'd7);
            mem_wait = (k == 1 || k == 2);
            compute_expect(); #2;
            checks++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== exp_ctrl) begin
                errors++;
                $display("[TB] FAIL div_dep_ctrl cycle %0d got %b expected %b", k, {stall_if, stall_id, flush_id, flush_ex}, exp_ctrl);
            end
            tick();
            k++;
        end while (exp_ctrl != 4'b0000 && k < 30);
        checks++;
        if (k >= 30) begin
            errors++;
            $display("[TB] FAIL div_budget got %0d cycles expected under 30", k);
        end
        set_idle();
    endtask

    task automatic test_waw();
        int k;
        bit issued;
        set_write(5'd3, 3'd5);
        tick();
        k = 0;
        issued = 0;
        while (!issued && k < 20) begin
            set_write(5'd3, 3'd0);
            compute_expect(); #2;
            checks++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== exp_ctrl) begin
                errors++;
                $display("[TB] FAIL waw_ctrl cycle %0d got %b expected %b", k, {stall_if, stall_id, flush_id, flush_ex}, exp_ctrl);
            end
            issued = exp_issue;
            tick();
            k++;
        end
        set_read(5'd3);
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL waw_after_alu got %b expected 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch();
        set_write(5'd9, 3'd3);
        tick();
        set_read(5'd9);
        rd_id = 5'd10; we_id = 1; lat_id = 3'd4;
        branch_taken_ex = 1;
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL branch_ctrl got %b expected 0011", {stall_if, stall_id, flush_id, flush_ex});
        end
        tick();
        // x10 was squashed, so reading it must not stall.
        set_read(5'd10);
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL branch_squash got %b expected 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        tick();
        set_idle();
    endtask

    task automatic test_wb_same_cycle();
        set_write(5'd4, 3'd1);
        tick();
        set_idle();
        tick();
        set_write(5'd4, 3'd2);
        wb_valid = 1; wb_rd = 5'd4;
        tick();
        for (int c = 0; c < 4; c++) begin
            set_read(5'd4);
            compute_expect(); #2;
            checks++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== exp_ctrl) begin
                errors++;
                $display("[TB] FAIL wb_issue_ctrl cycle %0d got %b expected %b", c, {stall_if, stall_id, flush_id, flush_ex}, exp_ctrl);
            end
            tick();
        end
        set_write(5'd0, 3'd7);
        tick();
        set_read(5'd0);
        rs2_used = 1; rs2_id = 5'd0;
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL x0_never_busy got %b expected 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        tick();
        set_idle();
    endtask

    task automatic test_perf();
        longint want_s;
        longint want_f;
        set_idle();
        rst = 1;
        tick();
        rst = 0;
        set_write(5'd5, 3'd1);
        tick();
        set_read(5'd5);
        tick();
        tick();
        set_write(5'd9, 3'd3);
        tick();
        set_read(5'd9);
        branch_taken_ex = 1;
        tick();
        set_idle();
        #2;
`ifdef HAZARD_PERF_CNT_EN
        want_s = 1;
        want_f = 1;
`else
        want_s = 0;
        want_f = 0;
`endif
        checks++;
        if (stall_cycles !== CNT_W'(want_s)) begin
            errors++;
            $display("[TB] FAIL perf_stall got %0d expected %0d", stall_cycles, want_s);
        end
        checks++;
        if (flush_count !== CNT_W'(want_f)) begin
            errors++;
            $display("[TB] FAIL perf_flush got %0d expected %0d", flush_count, want_f);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_write(5'd6, 3'd7);
        tick();
        set_read(5'd6);
        tick();
        rst = 1;
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL rst_cycle_ctrl got %b expected 1101", {stall_if, stall_id, flush_id, flush_ex});
        end
        tick();
        rst = 0;
        compute_expect(); #2;
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rst_mid_stall_ctrl got %b expected 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        checks++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_stall_counters got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        tick();
        set_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            id_valid        = ($urandom_range(0, 9) < 8);
            rs1_id          = 5'($urandom_range(0, 7));
            rs2_id          = 5'($urandom_range(0, 7));
            rs1_used        = $urandom_range(0, 1) == 1;
            rs2_used        = $urandom_range(0, 1) == 1;
            rd_id           = 5'($urandom_range(0, 7));
            we_id           = $urandom_range(0, 1) == 1;
            lat_id          = 3'($urandom_range(0, 7));
            wb_valid        = ($urandom_range(0, 9) < 3);
            wb_rd           = 5'($urandom_range(0, 7));
            branch_taken_ex = ($urandom_range(0, 9) == 0);
            mem_wait        = ($urandom_range(0, 19) < 3);
            rst             = ($urandom_range(0, 99) == 0);
            compute_expect(); #2;
            checks++;
            if ({stall_if, stall_id, flush_id, flush_ex} !== exp_ctrl) begin
                errors++;
                $display("[TB] FAIL random_ctrl cycle %0d got %b expected %b", c, {stall_if, stall_id, flush_id, flush_ex}, exp_ctrl);
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if (stall_cycles !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush)) begin
                errors++;
                $display("[TB] FAIL random_perf cycle %0d got %0d/%0d expected %0d/%0d", c, stall_cycles, flush_count, m_stall, m_flush);
            end
`endif
            tick();
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        model_clear();
        rst = 1;
        set_idle();
        #1;
        test_reset();
        test_load_use();
        test_div_memwait();
        test_waw();
        test_branch();
        test_wb_same_cycle();
        test_perf();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
